updown_counter_sequencer: RTL
=============================

# updown_counter_sequencer

Command-driven sequencer that owns one loadable up/down counter instance in the counters library and runs programmed count segments on it. A segment loads a start value, steps the counter toward an end value in a chosen direction at a programmable rate, then reports completion with wrap, abort and step-count status. It sits between a control master (valid/ready command channel) and the counter's enable / up_down / load_en / load_val pins.

## Interface
- WIDTH, 8: counter width; all value ports.
- DIV_WIDTH, 8: width of the step-rate divider field.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_start  in  WIDTH  value loaded into counter.
- cmd_end  in  WIDTH  terminal value.
- cmd_up  in  1  1: count up, 0: count down.
- cmd_div  in  DIV_WIDTH  one step every cmd_div+1 RUN cycles.
- abort  in  1  terminate active segment.
- cnt_enable  out  1  to counter enable.
- cnt_up_down  out  1  to counter up_down.
- cnt_load_en  out  1  to counter load_en.
- cnt_load_val  out  WIDTH  to counter load_val.
- cnt_count  in  WIDTH  from counter count.
- cnt_overflow  in  1  from counter overflow.
- cnt_underflow  in  1  from counter underflow.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- st_aborted  out  1  last segment ended by abort.
- st_wrapped  out  1  last segment crossed the all-ones/all-zeros boundary.
- st_steps  out  WIDTH+1  steps issued in last segment (saturating at all-ones).

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset -> IDLE.
- IDLE: cmd_ready=1. On handshake latch start/end/up/div; clear st_aborted, st_wrapped, st_steps; -> LOAD. abort ignored.
- LOAD (exactly one cycle): cnt_enable=1, cnt_load_en=1, cnt_load_val=start_lat; clear divider psc=0; -> RUN. abort in LOAD -> DONE with st_aborted=1, no load suppression (load still issued that cycle).
- RUN, priority order each cycle:
  1. cnt_count == end_lat -> DONE, no step.
  2. abort -> DONE, st_aborted=1, no step.
  3. psc == div_lat -> step: cnt_enable=1, cnt_up_down=up_lat, psc=0, st_steps+=1 (saturating); if (up_lat && cnt_overflow) || (!up_lat && cnt_underflow) set st_wrapped.
  4. else psc+=1.
- Wrong-direction targets are legal: counter wraps modulo 2^WIDTH, st_wrapped=1.
- DONE (one cycle): done=1; -> IDLE. Status outputs hold until next accept.
- cnt_load_val drives start_lat at all times; cnt_up_down drives up_lat outside steps; cnt_enable, cnt_load_en are 0 except as above.
- Block never resets the counter; on rst, cnt_enable=0 so the counter holds its value.

## Timing
- Handshake at cycle T; LOAD at T+1; counter holds start at T+2 (first RUN cycle).
- N = steps to reach end = (end-start) mod 2^WIDTH (up) or (start-end) mod 2^WIDTH (down); D = cmd_div.
- Step k issued at T+1+k(D+1); match seen at T+2+N(D+1); done pulse at T+3+N(D+1); cmd_ready high again at T+4+N(D+1).
- start==end: done at T+3, st_steps=0.
- Abort seen in RUN cycle C: done at C+1, count frozen at its cycle-C value.
- Reset values (cycle after rst sampled high, and while rst high): state IDLE, cmd_ready=0 while rst=1 then 1, busy=0, done=0, cnt_enable=0, cnt_load_en=0, cnt_up_down=0, cnt_load_val=0, st_aborted=0, st_wrapped=0, st_steps=0, psc=0.
- rst mid-segment: immediate return to IDLE, no done pulse.
- cmd_valid while busy: cmd_ready=0, command held by master, not dropped.

## Test plan
- WIDTH=8, start=10, end=15, up, div=0 -> load at T+1, counts 11..15, done at T+8, st_steps=5, wrapped=0.
- start=2, end=254, down, div=0 -> passes 0->255, st_wrapped=1, st_steps=4, done at T+7.
- start=0, end=3, up, div=2 -> steps at T+4, T+7, T+10; done at T+12, st_steps=3.
- start=end=77 -> no step, cnt_enable only in LOAD, done at T+3, st_steps=0.
- start=0, end=200, up, abort at count=50 -> done next cycle, st_aborted=1, counter holds 50; abort and match same cycle -> st_aborted=0.
- rst asserted mid-RUN and cmd_valid held during busy -> no done, outputs at reset values, held command accepted the first cycle cmd_ready=1.

Source files
------------

// File: rtl/updown_counter_sequencer.sv
// Runs programmed count segments on an external loadable up/down counter:
// load start, step toward end at a divided rate, report wrap/abort/step status.
module updown_counter_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_start,
  input  logic [WIDTH-1:0]     cmd_end,
  input  logic                 cmd_up,
  input  logic [DIV_WIDTH-1:0] cmd_div,
  input  logic                 abort,
  output logic                 cnt_enable,
  output logic                 cnt_up_down,
  output logic                 cnt_load_en,
  output logic [WIDTH-1:0]     cnt_load_val,
  input  logic [WIDTH-1:0]     cnt_count,
  input  logic                 cnt_overflow,
  input  logic                 cnt_underflow,
  output logic                 busy,
  output logic                 done,
  output logic                 st_aborted,
  output logic                 st_wrapped,
  output logic [WIDTH:0]       st_steps
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_start, r_end;
  logic                 r_up;
  logic [DIV_WIDTH-1:0] r_div, r_psc;
  logic                 r_aborted, r_wrapped;
  logic [WIDTH:0]       r_steps;

  logic w_accept, w_match, w_step, w_wrap;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_match  = (r_state == S_RUN) && (cnt_count == r_end);
  // Match outranks abort, abort outranks the step.
  assign w_step   = (r_state == S_RUN) && !w_match && !abort && (r_psc == r_div);
  assign w_wrap   = r_up ? cnt_overflow : cnt_underflow;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  w_next = abort ? S_DONE : S_RUN;
      S_RUN:   if (w_match || abort) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are gated by rst so the counter holds while in reset.
  always_comb begin
    cmd_ready    = !rst && (r_state == S_IDLE);
    busy         = !rst && (r_state != S_IDLE);
    done         = !rst && (r_state == S_DONE);
    cnt_load_en  = !rst && (r_state == S_LOAD);
    cnt_enable   = !rst && ((r_state == S_LOAD) || w_step);
    cnt_up_down  = r_up;
    cnt_load_val = r_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start   <= '0;
      r_end     <= '0;
      r_up      <= 1'b0;
      r_div     <= '0;
      r_psc     <= '0;
      r_aborted <= 1'b0;
      r_wrapped <= 1'b0;
      r_steps   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_start   <= cmd_start;
          r_end     <= cmd_end;
          r_up      <= cmd_up;
          r_div     <= cmd_div;
          r_aborted <= 1'b0;
          r_wrapped <= 1'b0;
          r_steps   <= '0;
        end
        S_LOAD: begin
          r_psc <= '0;
          if (abort) r_aborted <= 1'b1;
        end
        S_RUN: if (!w_match) begin
          if (abort) r_aborted <= 1'b1;
          else if (w_step) begin
            r_psc <= '0;
            if (r_steps != '1) r_steps <= r_steps + (WIDTH+1)'(1);
            if (w_wrap) r_wrapped <= 1'b1;
          end else begin
            r_psc <= r_psc + DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign st_aborted = r_aborted;
  assign st_wrapped = r_wrapped;
  assign st_steps   = r_steps;

endmodule
